store_write_port: RTL
=====================

Name: store_write_port

Overview:
- Write-side counterpart of the instruction fetch path.
- Accepts store requests from the LSU and buffers them in a small FIFO.
- Converts each store into an 8-byte-aligned memory write: aligned address, lane-shifted data and byte mask.
- Drives the write onto the pmem write interface with a valid/ready handshake, waits for a write response, and flags misaligned stores and response timeouts.

Parameters:
- DEPTH, 2, store buffer entries; power of 2, ≥2.
- TIMEOUT, 255, maximum cycles in WAIT_RESP before a timeout error; range 1..65535.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  buffer can accept a request.
- st_addr  in  64  byte address.
- st_data  in  64  store data, right-justified.
- st_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- mem_wvalid  out  1  write request valid.
- mem_wready  in  1  memory accepts write.
- mem_waddr  out  64  {st_addr[63:3], 3'b000}.
- mem_wdata  out  64  lane-aligned data.
- mem_wmask  out  8  byte enables.
- mem_bvalid  in  1  write response.
- mem_bready  out  1  ready for response.
- misalign_err  out  1  one-cycle pulse: misaligned store dropped.
- timeout_err  out  1  one-cycle pulse: response timeout.
- err_addr  out  64  st_addr of last misaligned store.
- drained  out  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and count = 0, FSM = IDLE, timeout counter = 0.
  - All outputs 0, except st_ready=1 and drained=1.
- Accept:
  - A request is accepted when st_valid && st_ready.
  - st_ready = (count != DEPTH), computed from registered count only.
  - A pop in the same cycle does not free a slot for that cycle.
- Misalignment:
  - half with addr[0]≠0, word with addr[1:0]≠0, dword with addr[2:0]≠0.
  - The request is still accepted (handshake completes) but not enqueued.
  - Next cycle: misalign_err=1 for one cycle; err_addr=st_addr, held until the next misaligned store.
- Encoding at enqueue (off = addr[2:0]):
  - mask: byte 8'h01<<off, half 8'h03<<off, word 8'h0F<<off, dword 8'hFF.
  - wdata = st_data << (8*off), truncated to 64 bits.
  - The aligned address, wdata and mask are stored per entry.
- FSM IDLE:
  - If FIFO is non-empty, go to SEND next cycle.
  - Head-of-FIFO entry drives mem_waddr/wdata/wmask.
- FSM SEND:
  - mem_wvalid=1.
  - waddr/wdata/wmask stay stable until mem_wready=1.
  - On the handshake cycle, go to WAIT_RESP and clear the counter.
- FSM WAIT_RESP:
  - mem_bready=1 and mem_wvalid=0; counter increments each cycle.
  - On mem_bvalid: pop the head entry and go to IDLE.
  - Else if counter==TIMEOUT-1: pop the head entry, pulse timeout_err the next cycle, go to IDLE.
  - If mem_bvalid and the timeout expiry fall in the same cycle, the response wins (no error).
- Ordering and throughput:
  - Writes issue strictly in FIFO order, one outstanding write at a time.
  - Minimum 3 cycles per write: IDLE→SEND→WAIT_RESP.
- Other rules:
  - mem_bvalid outside WAIT_RESP is ignored.
  - Pointers wrap modulo DEPTH.
  - drained = (count==0) && (state==IDLE).
- Reset mid-operation: the FIFO is discarded, any in-flight write is abandoned, and mem_wvalid drops asynchronously.

Test Plan:
1. Byte store addr=0x80000005, data=0xAB, memory ready/resp in 1 cycle → waddr=0x80000000, wmask=0x20, wdata=0x0000AB0000000000, one write, then drained=1.
2. Word store addr=0x80000002 → st_ready handshake completes; misalign_err pulses once; err_addr=0x80000002; mem_wvalid stays 0.
3. Three back-to-back dword stores with mem_wready held low, DEPTH=2 → st_ready=0 after two accepts. Then release mem_wready → writes issue in order and the third store is accepted once count drops.
4. mem_wready low for 10 cycles in SEND → waddr/wdata/wmask unchanged throughout; single handshake.
5. mem_bvalid never asserted, TIMEOUT=4 → timeout_err pulse exactly once, head entry popped, next entry proceeds.
6. Assert reset low during WAIT_RESP with 2 entries queued → outputs immediately return to reset values; drained=1 and st_ready=1 after reset releases.

Source files
------------

// File: rtl/store_write_port_if.sv
// Store write port bus: the LSU store request channel and the pmem write channel.
// master - the store write port (accepts stores, issues memory writes)
// slave  - the environment (LSU driving stores, memory accepting writes)
interface store_write_port_if;
    // LSU store request channel
    logic        st_valid;
    logic        st_ready;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic [1:0]  st_size;

    // pmem write channel
    logic        mem_wvalid;
    logic        mem_wready;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_bvalid;
    logic        mem_bready;

    modport master (
        input  st_valid, st_addr, st_data, st_size,
        output st_ready,
        output mem_wvalid, mem_waddr, mem_wdata, mem_wmask, mem_bready,
        input  mem_wready, mem_bvalid
    );

    modport slave (
        output st_valid, st_addr, st_data, st_size,
        input  st_ready,
        input  mem_wvalid, mem_waddr, mem_wdata, mem_wmask, mem_bready,
        output mem_wready, mem_bvalid
    );
endinterface

// File: rtl/store_write_port.sv
// Store write port: buffers LSU stores in a small FIFO, turns each into an 8-byte-aligned
// masked memory write and issues them one at a time with a valid/ready write handshake
// followed by a write response wait.
// Ports:
//   clk          - clock, rising edge
//   reset        - asynchronous active-low reset
//   bus          - store request + pmem write channels (master modport)
//   misalign_err - one-cycle pulse when a misaligned store is dropped
//   timeout_err  - one-cycle pulse when a write response does not arrive in time
//   err_addr     - address of the most recent misaligned store
//   drained      - FIFO empty and no write in progress
module store_write_port #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    store_write_port_if.master  bus,
    output logic                misalign_err,
    output logic                timeout_err,
    output logic [63:0]         err_addr,
    output logic                drained
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);
    localparam logic [15:0]     TmoLast   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSend, StWaitResp} state_e;

    state_e          state_q, state_d;
    logic [15:0]     tmo_cnt_q, tmo_cnt_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            misalign_q, timeout_q;
    logic [63:0]     err_addr_q;

    // Per-entry storage: aligned address (bits 63:3), lane-shifted data, byte mask
    logic [60:0] addr_mem [DEPTH];
    logic [63:0] data_mem [DEPTH];
    logic [7:0]  mask_mem [DEPTH];

    logic        accept, push, pop, misaligned, tmo_fire;
    logic [2:0]  off;
    logic [7:0]  base_mask, enc_mask;
    logic [63:0] enc_data;

    // Ready depends only on the registered count, so a same-cycle pop never frees a slot
    assign bus.st_ready = (count_q != CountFull);
    assign accept       = bus.st_valid && bus.st_ready;
    assign push         = accept && !misaligned;
    assign off          = bus.st_addr[2:0];

    always_comb begin
        misaligned = 1'b0;
        base_mask  = 8'h01;
        unique case (bus.st_size)
            2'd0: begin base_mask = 8'h01; misaligned = 1'b0;             end
            2'd1: begin base_mask = 8'h03; misaligned = bus.st_addr[0];   end
            2'd2: begin base_mask = 8'h0F; misaligned = |bus.st_addr[1:0]; end
            2'd3: begin base_mask = 8'hFF; misaligned = |bus.st_addr[2:0]; end
            default: ;
        endcase
    end

    assign enc_mask = base_mask << off;
    assign enc_data = bus.st_data << {off, 3'b000};

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
                mask_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_mem[wr_ptr_q] <= bus.st_addr[63:3];
                data_mem[wr_ptr_q] <= enc_data;
                mask_mem[wr_ptr_q] <= enc_mask;
                wr_ptr_q           <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Write FSM state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        pop       = 1'b0;
        tmo_fire  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) state_d = StSend;
            end
            StSend: begin
                if (bus.mem_wready) begin
                    state_d   = StWaitResp;
                    tmo_cnt_d = '0;
                end
            end
            StWaitResp: begin
                // A response arriving on the expiry cycle takes priority over the timeout
                if (bus.mem_bvalid) begin
                    pop     = 1'b1;
                    state_d = StIdle;
                end else if (tmo_cnt_q == TmoLast) begin
                    pop      = 1'b1;
                    tmo_fire = 1'b1;
                    state_d  = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Error reporting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            misalign_q <= accept && misaligned;
            timeout_q  <= tmo_fire;
            if (accept && misaligned) err_addr_q <= bus.st_addr;
        end
    end

    // Head entry is presented continuously; it only matters while mem_wvalid is high
    assign bus.mem_waddr  = {addr_mem[rd_ptr_q], 3'b000};
    assign bus.mem_wdata  = data_mem[rd_ptr_q];
    assign bus.mem_wmask  = mask_mem[rd_ptr_q];
    assign bus.mem_wvalid = (state_q == StSend);
    assign bus.mem_bready = (state_q == StWaitResp);

    assign misalign_err = misalign_q;
    assign timeout_err  = timeout_q;
    assign err_addr     = err_addr_q;
    assign drained      = (count_q == '0) && (state_q == StIdle);

endmodule
